// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter sharing one output channel between four
// packet sources. A grant is held for a whole packet (until 'last') or until
// MAX_BEATS beats have been accepted, after which the source re-arbitrates.
module rr_mux_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BEATS = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           in_valid,
   input  logic [3:0]           in_last,
   input  logic [4*WIDTH-1:0]   in_data,
   output logic [3:0]           in_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_last,
   input  logic                 out_ready,
   output logic [1:0]           sel,
   output logic                 busy
);

   localparam int CW = $clog2(MAX_BEATS + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      sel_q, sel_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            pick_found;
   logic [1:0]      pick_idx;
   logic [1:0]      cand;
   logic            grant;
   logic            accept;

   // Rotating-priority search: first requester after the last granted source.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = ptr_q;
      cand       = '0;
      for (int unsigned k = 1; k <= 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!pick_found && in_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Handshake gating: only the granted source sees ready; nothing moves while rst is high.
   always_comb begin
      grant     = (state_q == ST_GRANT) && !rst;
      out_valid = grant & in_valid[sel_q];
      out_last  = out_valid & in_last[sel_q];
      out_data  = in_data[int'(sel_q)*WIDTH +: WIDTH];
      in_ready  = '0;
      in_ready[sel_q] = grant & out_ready;
      accept    = out_valid & out_ready;
      sel       = sel_q;
      busy      = (state_q == ST_GRANT);
   end

   // Next-state: arbitrate in IDLE, count beats and detect release in GRANT.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d = ST_GRANT;
               sel_d   = pick_idx;
               ptr_d   = pick_idx;
               cnt_d   = '0;
            end
         end
         ST_GRANT: begin
            if (accept) begin
               cnt_d = cnt_q + 1'b1;
               if (in_last[sel_q] || (cnt_q == LAST_CNT)) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with synchronous reset; ptr=3 gives source 0 first priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         ptr_q   <= 2'd3;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: per-source beat queues feed the DUT, a cycle-level
// reference model predicts every output, and directed scenarios check the
// grant/data order against hand-derived sequences.
module tb_rr_mux_arbiter;

   localparam int WIDTH = 8;
   localparam int MAXB  = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [3:0]           in_valid;
   logic [3:0]           in_last;
   logic [4*WIDTH-1:0]   in_data;
   logic [3:0]           in_ready;
   logic                 out_valid;
   logic [WIDTH-1:0]     out_data;
   logic                 out_last;
   logic                 out_ready;
   logic [1:0]           sel;
   logic                 busy;

   always #5 clk = ~clk;

   rr_mux_arbiter #(.WIDTH(WIDTH), .MAX_BEATS(MAXB)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .sel       (sel),
      .busy      (busy)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state: is a source owning the channel, which one,
   // who was served last, and how many beats it has moved this grant.
   int m_busy = 0;
   int m_sel  = 0;
   int m_ptr  = 3;
   int m_cnt  = 0;

   // Source beat queues ({last, data}) and per-source valid permission.
   logic [WIDTH:0]   mem [4][64];
   int               head [4];
   int               tail [4];
   logic [3:0]       permit;

   int               log_src[$];
   logic [WIDTH-1:0] log_data[$];

   int               e3_src  [4] = '{2, 2, 2, 1};
   int               e3_dat  [4] = '{'hA0, 'hA1, 'hA2, 'hB0};
   int               e2_src  [5] = '{0, 1, 2, 3, 0};
   int               e5_src  [7] = '{0, 0, 0, 0, 3, 0, 0};
   int               e5_dat  [7] = '{'h50, 'h51, 'h52, 'h53, 'h30, 'h54, 'h55};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push(input int s, input logic [WIDTH-1:0] d, input logic l);
      mem[s][tail[s] % 64] = {l, d};
      tail[s]++;
   endtask

   task automatic clear_all();
      for (int i = 0; i < 4; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      log_src.delete();
      log_data.delete();
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         if (head[i] < tail[i]) begin
            in_valid[i]                 = permit[i];
            in_data[i*WIDTH +: WIDTH]   = mem[i][head[i] % 64][WIDTH-1:0];
            in_last[i]                  = mem[i][head[i] % 64][WIDTH];
         end else begin
            in_valid[i]                 = 1'b0;
            in_data[i*WIDTH +: WIDTH]   = WIDTH'($urandom);
            in_last[i]                  = 1'($urandom);
         end
      end
   endtask

   // One clock cycle: drive, check every output at negedge, then advance the model.
   task automatic tick();
      int         g, acc, best, bp, pr;
      logic       ev, el;
      logic [3:0] er;
      logic [WIDTH-1:0] ed;
      drive();
      @(negedge clk);
      g  = (m_busy != 0) && !rst;
      ev = (g != 0) && in_valid[m_sel];
      el = ev && in_last[m_sel];
      er = '0;
      if (g != 0 && out_ready) er[m_sel] = 1'b1;
      ed = in_data[m_sel*WIDTH +: WIDTH];
      chk("in_ready",  in_ready,  er);
      chk("out_valid", out_valid, ev);
      chk("out_last",  out_last,  el);
      chk("out_data",  out_data,  ed);
      chk("sel",       sel,       m_sel);
      chk("busy",      busy,      m_busy);
      acc = ev && out_ready;
      @(posedge clk);
      if (rst) begin
         m_busy = 0; m_sel = 0; m_ptr = 3; m_cnt = 0;
      end else if (m_busy == 0) begin
         if (in_valid != 4'b0) begin
            best = 0; bp = 9;
            for (int i = 0; i < 4; i++) begin
               pr = (i - m_ptr + 3) % 4;
               if (in_valid[i] && pr < bp) begin
                  bp = pr; best = i;
               end
            end
            m_sel = best; m_ptr = best; m_cnt = 0; m_busy = 1;
         end
      end else if (acc != 0) begin
         m_cnt++;
         log_src.push_back(m_sel);
         log_data.push_back(in_data[m_sel*WIDTH +: WIDTH]);
         head[m_sel]++;
         if (in_last[m_sel] || m_cnt == MAXB) m_busy = 0;
      end
      #1;
   endtask

   task automatic reset_pulse();
      clear_all();
      permit = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      permit = '0;
      out_ready = 1'b0;
      clear_all();
      drive();
      @(posedge clk);
      #1;

      // T1: reset held two cycles with all sources requesting.
      for (int i = 0; i < 4; i++) begin
         push(i, WIDTH'(8'h10 + i), 1'b1);
         push(i, WIDTH'(8'h20 + i), 1'b1);
      end
      permit = 4'hF;
      out_ready = 1'b1;
      tick();
      chk("t1_in_ready", in_ready, 4'h0);
      chk("t1_out_valid", out_valid, 1'b0);
      chk("t1_busy", busy, 1'b0);
      chk("t1_sel", sel, 2'd0);
      tick();
      rst = 1'b0;

      // T2: all requesting, single-beat packets -> 0,1,2,3,0 with bubbles.
      for (int c = 0; c < 10; c++) tick();
      chk("t2_count", log_src.size(), 5);
      for (int k = 0; k < 5; k++)
         chk("t2_src", (k < log_src.size()) ? log_src[k] : -1, e2_src[k]);

      // T3: packet lock on src2 while src1 waits, with a valid gap mid-packet.
      reset_pulse();
      push(2, 8'hA0, 1'b0);
      push(2, 8'hA1, 1'b0);
      push(2, 8'hA2, 1'b1);
      push(1, 8'hB0, 1'b1);
      out_ready = 1'b1;
      permit = 4'b0100; tick();
      permit = 4'b0110; tick();
      permit = 4'b0010; tick();
      permit = 4'b0110;
      for (int c = 0; c < 5; c++) tick();
      chk("t3_count", log_src.size(), 4);
      for (int k = 0; k < 4; k++) begin
         chk("t3_src", (k < log_src.size()) ? log_src[k] : -1, e3_src[k]);
         chk("t3_data", (k < log_data.size()) ? int'(log_data[k]) : -1, e3_dat[k]);
      end

      // T4: backpressure for five cycles, then exactly one beat per ready cycle.
      reset_pulse();
      push(1, 8'hC0, 1'b0);
      push(1, 8'hC1, 1'b0);
      push(1, 8'hC2, 1'b1);
      permit = 4'hF;
      out_ready = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("t4_out_valid", out_valid, 1'b1);
         chk("t4_out_data", out_data, 8'hC0);
         chk("t4_in_ready", in_ready, 4'h0);
      end
      chk("t4_none", log_src.size(), 0);
      out_ready = 1'b1; tick();
      out_ready = 1'b0; tick();
      chk("t4_one", log_src.size(), 1);
      chk("t4_first", (log_data.size() > 0) ? int'(log_data[0]) : -1, 'hC0);
      chk("t4_hold_data", out_data, 8'hC1);
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) tick();
      chk("t4_all", log_src.size(), 3);

      // T5: watchdog cuts src0 after MAXB beats, src3 gets its turn in between.
      reset_pulse();
      for (int k = 0; k < 6; k++) push(0, WIDTH'(8'h50 + k), (k == 5));
      push(3, 8'h30, 1'b1);
      permit = 4'hF;
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) tick();
      chk("t5_count", log_src.size(), 7);
      for (int k = 0; k < 7; k++) begin
         chk("t5_src", (k < log_src.size()) ? log_src[k] : -1, e5_src[k]);
         chk("t5_data", (k < log_data.size()) ? int'(log_data[k]) : -1, e5_dat[k]);
      end

      // T6: reset after two beats of a five-beat packet; no beat lost or duplicated.
      reset_pulse();
      for (int k = 0; k < 5; k++) push(2, WIDTH'(8'h60 + k), (k == 4));
      permit = 4'hF;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) tick();
      chk("t6_before", log_src.size(), 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive();
      chk("t6_busy", busy, 1'b0);
      chk("t6_in_ready", in_ready, 4'h0);
      chk("t6_during", log_src.size(), 2);
      for (int c = 0; c < 8; c++) tick();
      chk("t6_count", log_src.size(), 5);
      for (int k = 0; k < 5; k++)
         chk("t6_data", (k < log_data.size()) ? int'(log_data[k]) : -1, 'h60 + k);

      // Random traffic: variable packets, gaps, backpressure and rare resets.
      reset_pulse();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (head[i] == tail[i] && $urandom_range(0, 3) == 0) begin
               int len;
               len = $urandom_range(1, 6);
               for (int k = 0; k < len; k++) push(i, WIDTH'($urandom), (k == len - 1));
            end
         end
         permit    = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
